// File: rtl/apb_i2c_requester.sv
// APB requester that turns single-beat valid/ready commands into APB SETUP/ACCESS transfers
// towards the I2C controller. Optional ACCESS watchdog is enabled by defining APB_TIMEOUT_EN.
module apb_i2c_requester #(
  parameter int TIMEOUT = 255
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        pselx,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        cmd_ready_reg;
  logic        pwrite_reg;
  logic [31:0] paddr_reg;
  logic [31:0] pwdata_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;
  logic        rsp_timeout_reg;
  logic        accept;
  logic        unaligned;
  logic        timeout_hit;

  assign accept    = cmd_valid && cmd_ready_reg;
  assign unaligned = (cmd_addr[1:0] != 2'b00);

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // The abort fires in the TIMEOUT-th stalled ACCESS cycle; a pready in that cycle still wins.
  assign timeout_hit = (state_reg == ACCESS) && !pready && (count_reg == CNT_LAST);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      count_reg <= '0;
    end else if (state_next == SETUP) begin
      count_reg <= '0;
    end else if ((state_reg == ACCESS) && !pready) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end
`else
  // Without the watchdog only a degenerate TIMEOUT below 1 could ever abort an ACCESS.
  assign timeout_hit = (TIMEOUT < 1) && (state_reg == ACCESS) && !pready;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = unaligned ? RESP : SETUP;
        end
      end
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (pready || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg       <= IDLE;
      cmd_ready_reg   <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= (state_next == IDLE);

      if ((state_reg == IDLE) && accept) begin
        pwrite_reg <= cmd_write;
        paddr_reg  <= cmd_addr;
        pwdata_reg <= cmd_wdata;
        if (unaligned) begin
          rsp_rdata_reg   <= '0;
          rsp_err_reg     <= 1'b1;
          rsp_timeout_reg <= 1'b0;
        end
      end

      // prdata and pslverr are only meaningful in the pready cycle.
      if (state_reg == ACCESS) begin
        if (pready) begin
          rsp_rdata_reg   <= pwrite_reg ? 32'h0 : prdata;
          rsp_err_reg     <= pslverr;
          rsp_timeout_reg <= 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata_reg   <= '0;
          rsp_err_reg     <= 1'b1;
          rsp_timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign busy        = (state_reg != IDLE);
  assign pselx       = (state_reg == SETUP) || (state_reg == ACCESS);
  assign penable     = (state_reg == ACCESS);
  assign rsp_valid   = (state_reg == RESP);
  assign pwrite      = pwrite_reg;
  assign paddr       = paddr_reg;
  assign pwdata      = pwdata_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_i2c_requester.sv
// Directed plus randomized bench for apb_i2c_requester; expected cycle schedule and response
// come from a transaction-level model of the requester. Works with or without APB_TIMEOUT_EN.
module tb_apb_i2c_requester;

  localparam int TMO = 8;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb_i2c_requester #(.TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command through the requester with a reactive APB completer that raises pready
  // in the (waits+1)-th ACCESS cycle. Expected behaviour is derived from the transfer rules.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input bit serr);
    bit          unal;
    bit          to;
    int          n_access;
    int          resp_cycle;
    int          acc;
    logic [31:0] exp_rdata;
    bit          exp_err;

    unal     = (addr % 4) != 0;
    to       = 1'b0;
    n_access = waits + 1;
`ifdef APB_TIMEOUT_EN
    if (waits >= TMO) begin
      to       = 1'b1;
      n_access = TMO;
    end
`endif
    resp_cycle = unal ? 1 : 2 + n_access;
    exp_rdata  = (unal || to || wr) ? 32'h0 : rd;
    exp_err    = unal || to || serr;

    @(negedge pclk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(negedge pclk);
    acc = 0;
    for (int c = 1; c <= resp_cycle + 1; c++) begin
      // Commands offered while busy must be ignored; withdraw before IDLE returns.
      cmd_valid = (c <= resp_cycle) ? 1'($urandom) : 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;

      chk("pselx",   pselx,   (!unal && c <= 1 + n_access) ? 1 : 0);
      chk("penable", penable, (!unal && c >= 2 && c <= 1 + n_access) ? 1 : 0);
      chk("rsp_valid", rsp_valid, (c == resp_cycle) ? 1 : 0);
      chk("busy",    busy,    (c <= resp_cycle) ? 1 : 0);
      chk("paddr",   paddr,   addr);
      chk("pwrite",  pwrite,  wr);
      chk("pwdata",  pwdata,  wd);
      if (c >= resp_cycle) begin
        chk("rsp_rdata",   rsp_rdata,   exp_rdata);
        chk("rsp_err",     rsp_err,     exp_err);
        chk("rsp_timeout", rsp_timeout, to);
      end
      if (c == resp_cycle + 1) chk("cmd_ready_after", cmd_ready, 1);

      if (penable === 1'b1) acc++;
      if (penable === 1'b1 && acc == waits + 1) begin
        pready  = 1'b1;
        prdata  = rd;
        pslverr = serr;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
      if (c <= resp_cycle) @(negedge pclk);
    end
    pready = 1'b0;
    $display("txn wr=%0d addr=%h wdata=%h waits=%0d -> rdata=%h err=%0d timeout=%0d",
             wr, addr, wd, waits, exp_rdata, exp_err, to);
  endtask

  initial begin
    logic [31:0] aligned [5];
    aligned = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pselx", pselx, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rel_cmd_ready", cmd_ready, 1);

    // Directed scenarios.
    do_txn(1'b1, 32'h8, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b0, 32'h4, 32'h0, 3, 32'h0000_1234, 1'b0);
    do_txn(1'b1, 32'h0, 32'h5A5A_0F0F, 1, 32'hFFFF_FFFF, 1'b1);
    do_txn(1'b0, 32'h6, 32'h1111_2222, 0, 32'h3333_4444, 1'b0);

`ifdef APB_TIMEOUT_EN
    do_txn(1'b0, 32'h10, 32'h0, TMO - 1, 32'hCAFE_0001, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, TMO, 32'hCAFE_0002, 1'b0);
    do_txn(1'b1, 32'hC, 32'h0000_0077, 50, 32'hCAFE_0003, 1'b0);
`else
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    for (int i = 0; i < 100; i++) begin
      chk("stuck_busy", busy, 1);
      chk("stuck_penable", penable, 1);
      chk("stuck_rsp_timeout", rsp_timeout, 0);
      @(negedge pclk);
    end
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    $display("txn wr=0 addr=00000004 stuck for 100 cycles then reset");
`endif

    // Reset in the middle of an ACCESS phase.
    @(negedge pclk);
    chk("pre_abort_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("abort_in_access", penable, 1);
    presetn = 1'b0;
    @(negedge pclk);
    chk("abort_pselx", pselx, 0);
    chk("abort_penable", penable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("abort_rel_ready", cmd_ready, 1);
    chk("abort_rel_rsp_valid", rsp_valid, 0);
    $display("txn wr=0 addr=00000004 dropped by reset during ACCESS");
    do_txn(1'b1, 32'hC, 32'h0000_00C3, 0, 32'h0, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      int          sel;
      int          w;
      sel = $urandom_range(0, 5);
      if (sel == 5) a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else          a = aligned[sel];
`ifdef APB_TIMEOUT_EN
      w = $urandom_range(0, TMO + 2);
`else
      w = $urandom_range(0, 5);
`endif
      do_txn(1'($urandom), a, $urandom, w, $urandom, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
